product_bcd_converter: RTL and testbench
========================================

// Module: product_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double dabble). It sits directly downstream of
//  three_bit_multiplier and consumes its 6-bit product y. It returns the product as packed decimal
//  digits for display. Valid/ready handshake on both sides; one conversion in flight at a time.
// PARAMETERS
//  IN_W    6   binary input width; must be >= 2
//  DIGITS  2   BCD output digits; must satisfy 10**DIGITS > 2**IN_W-1 (elab-time $error otherwise)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          bin_in valid
//  in_ready   out  1          converter idle, can accept
//  bin_in     in   IN_W       unsigned binary (multiplier product y)
//  out_valid  out  1          bcd_out valid and stable
//  out_ready  in   1          consumer accepts bcd_out
//  bcd_out    out  4*DIGITS   packed BCD, digit 0 (units) in [3:0]
//  busy       out  1          conversion in progress (state SHIFT)
// BEHAVIOUR
//  - Reset (async, any state, including mid-conversion): state=IDLE, bit counter=0, BCD and shift
//    registers=0. Outputs: out_valid=0, bcd_out=0, busy=0, in_ready=1 (decoded from IDLE).
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE:  in_ready=1. On in_valid&&in_ready: load bin_in into the shift reg, clear BCD, cnt=IN_W,
//           go to SHIFT.
//    SHIFT: each cycle, add 3 to every BCD digit >=5, then shift {bcd,bin} left 1 (bin MSB enters
//           digit 0 LSB), then cnt--. After the cycle where cnt goes 1->0, go to DONE.
//    DONE:  out_valid=1; bcd_out is registered and held stable. On out_valid&&out_ready, go to IDLE.
//  - Latency: out_valid rises exactly IN_W clocks after the accepting edge (6 for defaults).
//  - Throughput: one result per IN_W+2 clocks at best. There is no same-cycle bypass: in_ready rises
//    the cycle after the out handshake.
//  - in_valid is ignored whenever in_ready=0. bin_in is sampled only on the accepting edge; later
//    changes have no effect.
//  - out_valid stays high with bcd_out unchanged for any number of out_ready=0 cycles (backpressure).
//  - out_ready while out_valid=0 has no effect.
//  - Boundaries: bin_in=0 gives all-zero digits. bin_in=2**IN_W-1 (63) gives 0x63. No digit ever
//    exceeds 9.
//  - All adjust/shift arithmetic is done on 4*DIGITS+IN_W bits. No truncation of the top digit.
// CONFIGURATION
//  BCD_SEG7_EN defined:
//    - adds output seg_out [7*DIGITS-1:0]: per-digit 7-segment code, gfedcba, active-high,
//      digit 0 in [6:0].
//    - seg_out is registered alongside bcd_out, =0 in reset and while out_valid=0, and held with
//      bcd_out.
//    - codes: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111
//      8=1111111 9=1101111.
//  BCD_SEG7_EN undefined: seg_out port and decoder absent; all other behaviour identical.
// TESTING
//  1. Reset, bin_in=49 (7*7) with in_valid pulse -> in_ready=0 next cycle, busy=1 for 6 clocks,
//     out_valid at +6, bcd_out=8'h49.
//  2. bin_in=0 -> bcd_out=8'h00 at +6. bin_in=63 -> bcd_out=8'h63. bin_in=21 (7*3) -> 8'h21.
//  3. Backpressure: 36 (6*6) converted, out_ready=0 for 5 clocks; in_valid=1 with bin_in=9 during
//     the stall -> bcd_out held 8'h36, new input not accepted. After out_ready=1: IDLE, then 9 is
//     accepted -> 8'h09.
//  4. Input hold: change bin_in 1 clock after acceptance (accept 20, then drive 1) -> result still
//     8'h20.
//  5. Assert rst at SHIFT cycle 3 -> out_valid=0, bcd_out=0, busy=0, in_ready=1 immediately. The next
//     conversion of 6 gives 8'h06.
//  6. With BCD_SEG7_EN: 49 -> seg_out={1100110,1101111}. 63 -> {1111101,1001111}. seg_out=0 while
//     out_valid=0.
//  Self-check all 64 inputs against $itobcd reference model: ((v/10)<<4)|(v%10).

Source files
------------

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) for the multiplier product.
// Optional 7-segment output enabled with the BCD_SEG7_EN macro.
module product_bcd_converter #(
    parameter int IN_W   = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BCD_SEG7_EN
    output logic [7*DIGITS-1:0]   seg_out,
`endif
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int W     = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    if (IN_W < 2) begin : g_bad_in_w
        $error("product_bcd_converter: IN_W must be >= 2");
    end
    if (10**DIGITS <= 2**IN_W - 1) begin : g_bad_digits
        $error("product_bcd_converter: DIGITS too small for IN_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      sr_q, sr_d;
    logic [W-1:0]      adj;
    logic [W-1:0]      shifted;
    logic [BCD_W-1:0]  bcd_q, bcd_d;

`ifdef BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_q, seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction
`endif

    // Digits sit above the binary field; adjust is done on the full width so
    // nothing falls off the top digit before the shift.
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[IN_W+4*i +: 4] >= 4'd5)
                adj[IN_W+4*i +: 4] = sr_q[IN_W+4*i +: 4] + 4'd3;
        end
        shifted = adj << 1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
`ifdef BCD_SEG7_EN
        seg_d   = seg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = {{BCD_W{1'b0}}, bin_in};
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    bcd_d   = shifted[W-1 -: BCD_W];
`ifdef BCD_SEG7_EN
                    for (int i = 0; i < DIGITS; i++)
                        seg_d[7*i +: 7] = seg7(shifted[IN_W+4*i +: 4]);
`endif
                end
            end
            DONE: begin
                // Result registers clear on the handshake so outputs read 0 when not valid.
                if (out_ready) begin
                    state_d = IDLE;
                    bcd_d   = '0;
`ifdef BCD_SEG7_EN
                    seg_d   = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bcd_q   <= '0;
`ifdef BCD_SEG7_EN
            seg_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
`ifdef BCD_SEG7_EN
            seg_q   <= seg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
`ifdef BCD_SEG7_EN
    assign seg_out   = seg_q;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: directed scenarios plus a shuffled
// sweep of every input under random output backpressure.
module tb_product_bcd_converter;

    localparam int IN_W   = 6;
    localparam int DIGITS = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      bin_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 busy;
`ifdef BCD_SEG7_EN
    logic [7*DIGITS-1:0]  seg_out;
`endif

    product_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
`ifdef BCD_SEG7_EN
        .seg_out   (seg_out),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_bcd_q[$];
    logic [31:0] exp_seg_q[$];

    // Decimal digits by plain division; segment patterns straight from the code table.
    function automatic logic [31:0] model_bcd(input int v);
        logic [31:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r |= 32'(v % 10) << (4 * i);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_seg(input int v);
        logic [6:0] tbl [10];
        logic [31:0] r = '0;
        tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        for (int i = 0; i < DIGITS; i++) begin
            r |= 32'(tbl[v % 10]) << (7 * i);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int v);
        exp_bcd_q.push_back(model_bcd(v));
        exp_seg_q.push_back(model_seg(v));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_bcd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %0h expected none", bcd_out);
            end else begin
                check("result_bcd", 32'(bcd_out), exp_bcd_q.pop_front());
`ifdef BCD_SEG7_EN
                check("result_seg", 32'(seg_out), exp_seg_q.pop_front());
`else
                void'(exp_seg_q.pop_front());
`endif
            end
        end
    end

    task automatic send(input int v);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
            return;
        end
        in_valid = 1'b1;
        bin_in   = IN_W'(v);
        @(posedge clk);
        push_exp(v);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_pct);
        int n = 0;
        while (exp_bcd_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) >= stall_pct);
            n++;
        end
        check("drain_done", 32'(exp_bcd_q.size()), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vals [64];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bin_in = '0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_bcd",       32'(bcd_out),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 49: latency, busy window, handshake and in_ready recovery
        send(49);
        check("t1_in_ready_low", 32'(in_ready), 32'd0);
        check("t1_busy_high",    32'(busy),     32'd1);
`ifdef BCD_SEG7_EN
        check("t1_seg_zero_busy", 32'(seg_out), 32'd0);
`endif
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("t1_out_valid_%0d", i), 32'(out_valid), 32'(i == 6));
            check($sformatf("t1_busy_%0d", i),      32'(busy),      32'(i < 6));
        end
        check("t1_bcd_49", 32'(bcd_out), 32'h49);
`ifdef BCD_SEG7_EN
        check("t1_seg_49", 32'(seg_out), 32'({7'b1100110, 7'b1101111}));
`endif
        @(posedge clk); #1;
        check("t1_in_ready_back", 32'(in_ready),  32'd1);
        check("t1_valid_dropped", 32'(out_valid), 32'd0);

        // boundaries and a plain product
        send(0);  drain(0);
        send(63); drain(0);
        send(21); drain(0);

        // backpressure: result held, new input refused
        out_ready = 1'b0;
        send(36);
        repeat (6) begin @(posedge clk); #1; end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            bin_in   = IN_W'(9);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_bcd_held", 32'(bcd_out),   32'h36);
            check("bp_no_accept", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 32'(in_ready),  32'd1);
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        push_exp(9);
        #1 in_valid = 1'b0;
        check("bp_accept_9", 32'(busy), 32'd1);
        drain(0);

        // input only sampled on the accepting edge
        send(20);
        bin_in = IN_W'(1);
        drain(0);

        // reset mid-conversion
        send(50);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_bcd",   32'(bcd_out),   32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        exp_bcd_q.delete();
        exp_seg_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        send(6); drain(0);

        // every input, shuffled, with idle gaps and random stalls
        for (int i = 0; i < 64; i++) vals[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j = $urandom_range(i);
            int t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(3)) begin @(posedge clk); #1; end
            out_ready = $urandom_range(1);
            send(vals[i]);
            drain(40);
        end

        repeat (4) begin @(posedge clk); #1; end
        check("sb_empty", 32'(exp_bcd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
